// File: rtl/serial_rx_aligner_pkg.sv
// Shared PHY definitions: comma symbol and lock-FSM state encodings used by the
// receive aligner and the transmit side.
package serial_rx_aligner_pkg;

    localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [1:0] ST_SEARCH   = 2'd0;
    localparam logic [1:0] ST_ALIGNING = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

endpackage

// File: rtl/com_lock_fsm.sv
// Comma lock FSM: bit-slides in SEARCH, counts aligned COM bytes in ALIGNING,
// and tracks byte boundaries once ACTIVE (left only by reset).
module com_lock_fsm
    import serial_rx_aligner_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic clk_32f,
    input  logic reset,
    input  logic cand_is_com_c,
    output logic active,
    output logic byte_done_c
);

    localparam int unsigned COM_CNT_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [COM_CNT_W-1:0] LOCK_CNT_C = COM_CNT_W'(LOCK_COUNT);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt;
    logic [COM_CNT_W-1:0] com_cnt;
    logic [COM_CNT_W-1:0] com_cnt_nxt;
    logic [COM_CNT_W-1:0] com_cnt_inc;
    logic                 wrap_c;

    assign com_cnt_inc = com_cnt + COM_CNT_W'(1);
    assign wrap_c      = (bit_cnt == '1);
    assign byte_done_c = (state == ST_ACTIVE) && wrap_c;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state   <= ST_SEARCH;
            bit_cnt <= '0;
            com_cnt <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            com_cnt <= com_cnt_nxt;
            active  <= (state_nxt == ST_ACTIVE);
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        com_cnt_nxt = com_cnt;
        case (state)
            ST_SEARCH: begin
                bit_cnt_nxt = '0;
                if (cand_is_com_c) begin
                    com_cnt_nxt = COM_CNT_W'(1);
                    state_nxt   = (LOCK_COUNT <= 1) ? ST_ACTIVE : ST_ALIGNING;
                end
            end
            ST_ALIGNING: begin
                if (wrap_c) begin
                    if (cand_is_com_c) begin
                        com_cnt_nxt = com_cnt_inc;
                        if (com_cnt_inc == LOCK_CNT_C) begin
                            state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        com_cnt_nxt = '0;
                        state_nxt   = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                state_nxt = ST_ACTIVE;
            end
            default: begin
                state_nxt   = ST_SEARCH;
                bit_cnt_nxt = '0;
                com_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/serial_rx_aligner.sv
// Serial receive byte aligner: locks onto a comma symbol and outputs bytes.
// Define SERIAL_RX_COM_STRIP_EN to suppress COM bytes from the locked output stream.
module serial_rx_aligner
    import serial_rx_aligner_pkg::*;
#(
    parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    // Only seven history bits are ever read; the incoming bit completes the byte.
    logic [BYTE_W-2:0] hist;
    logic [BYTE_W-1:0] candidate_c;
    logic              cand_is_com_c;
    logic              byte_done_c;
    logic              emit_c;

    assign candidate_c   = {hist, data_in};
    assign cand_is_com_c = (candidate_c == COM_SYMBOL);

    com_lock_fsm #(
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .cand_is_com_c (cand_is_com_c),
        .active        (active),
        .byte_done_c   (byte_done_c)
    );

`ifdef SERIAL_RX_COM_STRIP_EN
    assign emit_c = byte_done_c && !cand_is_com_c;
`else
    assign emit_c = byte_done_c;
`endif

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            hist      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            hist      <= candidate_c[BYTE_W-2:0];
            valid_out <= emit_c;
            if (emit_c) begin
                data_out <= candidate_c;
            end
        end
    end

endmodule
